// File: rtl/adder_4bit_reg.sv
// Registered ripple-carry adder leaf for datapath slices.
// The sum is built from an explicit chain of full-adder cells.
// Outputs load only on a valid sample. Otherwise they keep their last result,
// and out_valid marks the cycle that follows a capture.

// Single full-adder cell used to build the ripple chain.
module adder_4bit_reg_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

module adder_4bit_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  assign w_carry[0] = c;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    adder_4bit_reg_fa u_fa (
      .i_a    (a[g]),
      .i_b    (b[g]),
      .i_cin  (w_carry[g]),
      .o_s    (w_sum[g]),
      .o_cout (w_carry[g+1])
    );
  end

  // Signed overflow occurs when the carry into the MSB differs from the carry out.
  assign w_cout = w_carry[WIDTH];
  assign w_ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // Result registers load only on a valid sample and otherwise hold.
  // Reset wins over in_valid, so a sample taken during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_4bit_reg.sv
// Scoreboard bench for adder_4bit_reg. The driver pushes, for every clock edge,
// the response that a behavioural model expects. The monitor pops one entry
// after each edge and compares it with the DUT outputs.
module tb_adder_4bit_reg;

  localparam int W = 4;

  typedef struct {
    bit       v;
    bit [3:0] s;
    bit       co;
    bit       ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  bit [3:0] m_sum;
  bit       m_cout;
  bit       m_ovf;

  adder_4bit_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model works from integer arithmetic, not from the carry chain.
  task automatic cyc(input bit r, input bit v, input int av, input int bv, input int cv);
    exp_t e;
    int   tot;
    int   sa;
    int   sbv;
    int   st;
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    c        = cv[0];
    if (!r) begin
      m_sum = 0; m_cout = 0; m_ovf = 0;
      e.v = 0;
    end else if (v) begin
      tot    = av + bv + cv;
      m_sum  = tot[3:0];
      m_cout = (tot > 15);
      sa     = (av > 7) ? av - 16 : av;
      sbv    = (bv > 7) ? bv - 16 : bv;
      st     = sa + sbv + cv;
      m_ovf  = (st > 7) || (st < -8);
      e.v    = 1;
    end else begin
      e.v = 0;
    end
    e.s  = m_sum;
    e.co = m_cout;
    e.ov = m_ovf;
    sb_q.push_back(e);
  endtask

  // Monitor: after each edge, compare the outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (out_valid !== e.v) begin
        n_errors++;
        $display("FAIL out_valid: got %0b expected %0b at %0t", out_valid, e.v, $time);
      end
      n_checks++;
      if (sum !== e.s) begin
        n_errors++;
        $display("FAIL sum: got %b expected %b at %0t", sum, e.s, $time);
      end
      n_checks++;
      if (cout !== e.co) begin
        n_errors++;
        $display("FAIL cout: got %0b expected %0b at %0t", cout, e.co, $time);
      end
      n_checks++;
      if (ovf !== e.ov) begin
        n_errors++;
        $display("FAIL ovf: got %0b expected %0b at %0t", ovf, e.ov, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int da[5];
    int db[5];
    int waited;
    da = '{0, 2, 5, 3, 6};
    db = '{0, 1, 3, 4, 2};
    n_checks = 0;
    n_errors = 0;
    m_sum = 0; m_cout = 0; m_ovf = 0;
    rst_n = 0; in_valid = 0; a = 0; b = 0; c = 0;

    // Reset held with a live sample, then release.
    cyc(0, 1, 15, 15, 1);
    cyc(0, 1, 15, 15, 1);
    cyc(1, 1, 15, 15, 1);

    // Basic pattern, back to back, with carry-in 0 and then 1.
    for (int i = 0; i < 5; i++) cyc(1, 1, da[i], db[i], 0);
    cyc(1, 1, 7, 15, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, da[i], db[i], 1);
    cyc(1, 1, 15, 7, 1);

    // Outputs must hold while in_valid is low and the operands move.
    for (int i = 0; i < 3; i++)
      cyc(1, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

    // Wrap to zero, then reset arrives on the same edge as a valid sample.
    cyc(1, 1, 15, 0, 1);
    cyc(0, 1, 9, 9, 1);
    cyc(1, 0, 3, 3, 0);

    // Random traffic with in_valid mostly high.
    for (int i = 0; i < 1000; i++)
      cyc(1, ($urandom_range(0, 9) != 0), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

    cyc(1, 0, 0, 0, 0);

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_4bit_reg.md
Name: adder_4bit_reg

Overview:
- Registered 4-bit ripple-carry adder with carry-in and carry-out, used as a small arithmetic leaf in datapath slices.
- Computes a + b + c and registers the result after one clock edge.
- Also registers valid and signed-overflow status flags.
- The datapath is built from an explicit chain of full-adder cells (generate loop), not a behavioural "+".

Parameters:
- WIDTH, 4, operand and sum width in bits. Must be at least 1. All behaviour below is stated for the default of 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands valid this cycle; result is captured only when high.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c  input  1  carry-in.
- sum  output  WIDTH  registered (a + b + c) mod 2^WIDTH.
- cout  output  1  registered carry out of the MSB.
- ovf  output  1  registered two's-complement overflow.
- out_valid  output  1  high for the cycle in which sum, cout and ovf hold a fresh result.

Behaviour:
- One clock domain. Reset is synchronous and active-low: when rst_n = 0 at a rising clk edge, sum, cout, ovf and out_valid all clear to 0.
- Reset has priority over in_valid.
- Combinational core:
  - Ripple chain with carry[0] = c.
  - For each bit i: s[i] = a[i] ^ b[i] ^ carry[i], and carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i])).
  - cout_next = carry[WIDTH].
  - ovf_next = carry[WIDTH] ^ carry[WIDTH-1].
  - Equivalently, {cout, sum} = a + b + c as a (WIDTH+1)-bit unsigned value.
- Register update on a rising edge with rst_n = 1:
  - If in_valid = 1: sum, cout and ovf load the combinational results, and out_valid goes to 1.
  - If in_valid = 0: sum, cout and ovf hold their previous values, and out_valid goes to 0.
- Latency: exactly 1 cycle from the sampling edge to the output. Back-to-back in_valid gives one result per cycle; no backpressure.
- No internal state beyond the output registers; no FSM.
- Boundary conditions:
  - All-ones + 0 + c=1 wraps sum to 0 with cout = 1.
  - Operands of 0 with c = 0 give sum = 0, cout = 0, ovf = 0.
  - ovf is computed regardless of whether the caller treats operands as signed.
- Reset mid-stream: a result sampled in the same cycle as reset is discarded, and out_valid stays 0 on the following cycle.
- Inputs that are X while in_valid = 0 must not affect the outputs.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1, a = 4'b1111, b = 4'b1111, c = 1 -> sum = 0000, cout = 0, ovf = 0, out_valid = 0 throughout. Release reset -> next cycle shows sum = 1111, cout = 1, ovf = 0, out_valid = 1.
- Basic, c = 0, one per cycle with in_valid held high:
  - 0000+0000 -> sum 0000, cout 0.
  - 0010+0001 -> sum 0011, cout 0.
  - 0101+0011 -> sum 1000, cout 0, ovf 1.
  - 0011+0100 -> sum 0111, cout 0.
  - 0110+0010 -> sum 1000, cout 0, ovf 1.
  - Each result appears exactly 1 cycle after its sampling edge.
- Carry-out, c = 0: 0111+1111 -> sum 0110, cout 1, ovf 0.
- Carry-in, c = 1:
  - 0000+0000 -> sum 0001.
  - 0010+0001 -> sum 0100.
  - 0101+0011 -> sum 1001, ovf 1.
  - 0011+0100 -> sum 1000, ovf 1.
  - 0110+0010 -> sum 1001, ovf 1.
  - 1111+0111 -> sum 0111, cout 1, ovf 0.
- Hold and valid gating: after a result, drop in_valid and toggle a/b randomly for 3 cycles -> out_valid = 0, and sum, cout, ovf are unchanged.
- Wrap and reset mid-stream: 1111+0000+1 -> sum 0000, cout 1. Then drive in_valid = 1 and rst_n = 0 on the same edge -> all outputs 0 next cycle.
- Randomized check: 1000 random {a, b, c} against a (WIDTH+1)-bit reference sum, plus a signed-overflow check against a reference model.
